matrix_loader_2x2: RTL and testbench

- Upstream feeder for the team's 2x2 matrix transpose stage.
- Accepts matrix elements one per transfer over a valid/ready stream, in row-major order: a11, a12, a21, a22.
- Once all four are captured, presents them in parallel as a held 2x2 matrix with a valid/ready output handshake.
- The combinational transpose consumes that matrix directly; a completed-matrix counter supports debug.

---
 rtl/matrix_loader_2x2_pkg.sv | 18 +
 rtl/matrix_stream_transpose_2x2.sv | 54 +++++
 rtl/matrix_transpose_2x2.sv | 22 ++
 rtl/matrix_loader_2x2.sv | 89 ++++++++
 tb/tb_matrix_loader_2x2.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_loader_2x2_pkg.sv
// Shared definitions for the 2x2 matrix loader and transpose datapath:
// element width, row-major slot indices and the loader state encoding.
package matrix_pkg;

  localparam int ELEM_W = 3;

  // Row-major slot indices; also the values fill_idx steps through.
  localparam logic [1:0] IDX_A11 = 2'd0;
  localparam logic [1:0] IDX_A12 = 2'd1;
  localparam logic [1:0] IDX_A21 = 2'd2;
  localparam logic [1:0] IDX_A22 = 2'd3;

  typedef enum logic {
    ST_FILL = 1'b0,  // collecting elements
    ST_FULL = 1'b1   // holding a complete matrix for downstream
  } state_t;

endpackage

// File: rtl/matrix_stream_transpose_2x2.sv
// System wrapper: stream loader feeding the combinational 2x2 transpose.
module matrix_stream_transpose_2x2
  import matrix_pkg::*;
#(
  parameter int WIDTH     = ELEM_W,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     t11,
  output logic [WIDTH-1:0]     t12,
  output logic [WIDTH-1:0]     t21,
  output logic [WIDTH-1:0]     t22,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           fill_idx,
  output logic [CNT_WIDTH-1:0] mat_count
);

  logic [WIDTH-1:0] a11, a12, a21, a22;

  matrix_loader_2x2 #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_loader (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a11       (a11),
    .a12       (a12),
    .a21       (a21),
    .a22       (a22),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_idx  (fill_idx),
    .mat_count (mat_count)
  );

  matrix_transpose_2x2 #(.WIDTH(WIDTH)) u_transpose (
    .a11 (a11),
    .a12 (a12),
    .a21 (a21),
    .a22 (a22),
    .t11 (t11),
    .t12 (t12),
    .t21 (t21),
    .t22 (t22)
  );

endmodule

// File: rtl/matrix_transpose_2x2.sv
// Combinational 2x2 transpose: swaps the off-diagonal elements.
module matrix_transpose_2x2
  import matrix_pkg::*;
#(
  parameter int WIDTH = ELEM_W
) (
  input  logic [WIDTH-1:0] a11,
  input  logic [WIDTH-1:0] a12,
  input  logic [WIDTH-1:0] a21,
  input  logic [WIDTH-1:0] a22,
  output logic [WIDTH-1:0] t11,
  output logic [WIDTH-1:0] t12,
  output logic [WIDTH-1:0] t21,
  output logic [WIDTH-1:0] t22
);

  assign t11 = a11;
  assign t12 = a21;
  assign t21 = a12;
  assign t22 = a22;

endmodule

// File: rtl/matrix_loader_2x2.sv
// Serial-to-parallel loader: collects four row-major elements from a
// valid/ready stream and holds them as a 2x2 matrix until downstream takes it.
module matrix_loader_2x2
  import matrix_pkg::*;
#(
  parameter int WIDTH     = ELEM_W,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     a11,
  output logic [WIDTH-1:0]     a12,
  output logic [WIDTH-1:0]     a21,
  output logic [WIDTH-1:0]     a22,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           fill_idx,
  output logic [CNT_WIDTH-1:0] mat_count
);

  state_t state;
  logic   accept;
  logic   handoff;

  // In FULL the input side only opens when the held matrix leaves this
  // cycle, so the slot freed by the handoff (a11) can be refilled at once.
  assign in_ready  = (state == ST_FILL) ? 1'b1 : out_ready;
  assign out_valid = (state == ST_FULL);
  assign handoff   = out_valid && out_ready;
  // clear aborts a partial fill and beats any element offered alongside it;
  // in FULL it is ignored so a completed matrix is never dropped.
  assign accept    = in_valid && in_ready && !(clear && (state == ST_FILL));

  // Sequencing: slot pointer, FILL/FULL state and handed-off matrix count.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FILL;
      fill_idx  <= IDX_A11;
      mat_count <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (clear) begin
            fill_idx <= IDX_A11;
          end else if (accept) begin
            fill_idx <= fill_idx + 2'd1;  // wraps 3 -> 0 on the last slot
            if (fill_idx == IDX_A22) state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (handoff) begin
            mat_count <= mat_count + CNT_WIDTH'(1);
            state     <= ST_FILL;
            fill_idx  <= accept ? IDX_A12 : IDX_A11;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  // Element capture: write the slot under fill_idx on every accept. In FULL
  // an accept only happens with a handoff and fill_idx is already 0, so the
  // incoming element lands in a11 as the old matrix leaves.
  // NOTE: element registers are reset even though out_valid guards them,
  // because the reset values of a11..a22 are externally visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a11 <= '0;
      a12 <= '0;
      a21 <= '0;
      a22 <= '0;
    end else if (accept) begin
      case (fill_idx)
        IDX_A11: a11 <= in_data;
        IDX_A12: a12 <= in_data;
        IDX_A21: a21 <= in_data;
        IDX_A22: a22 <= in_data;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader_2x2.sv
// Directed bench for matrix_loader_2x2, with the stream-transpose wrapper
// driven by the same stimulus for the system-level transpose check.
module tb_matrix_loader_2x2;

  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          out_ready;

  logic          in_ready, out_valid;
  logic [W-1:0]  a11, a12, a21, a22;
  logic [1:0]    fill_idx;
  logic [CW-1:0] mat_count;

  logic          w_in_ready, w_out_valid;
  logic [W-1:0]  t11, t12, t21, t22;
  logic [1:0]    w_fill_idx;
  logic [CW-1:0] w_mat_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  matrix_loader_2x2 #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a11       (a11),
    .a12       (a12),
    .a21       (a21),
    .a22       (a22),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fill_idx  (fill_idx),
    .mat_count (mat_count)
  );

  matrix_stream_transpose_2x2 #(.WIDTH(W), .CNT_WIDTH(CW)) wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .t11       (t11),
    .t12       (t12),
    .t21       (t21),
    .t22       (t22),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .fill_idx  (w_fill_idx),
    .mat_count (w_mat_count)
  );

  // Advance one clock; inputs are changed and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one element for exactly one edge.
  task automatic send(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #3;
    vectors++;
    if ({out_valid, fill_idx, mat_count} !== {1'b0, 2'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ov=%b idx=%0d cnt=%0d, want ov=0 idx=0 cnt=0",
               out_valid, fill_idx, mat_count);
    end
    vectors++;
    if ({a11, a12, a21, a22} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_elems: got %0d %0d %0d %0d, want 0 0 0 0", a11, a12, a21, a22);
    end
    #4 rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic_fill();
    step();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if ({out_valid, in_ready, fill_idx} !== {1'b1, 1'b1, 2'd0}) begin
      miscompares++;
      $display("FAIL basic_full: got ov=%b ir=%b idx=%0d, want ov=1 ir=1 idx=0",
               out_valid, in_ready, fill_idx);
    end
    vectors++;
    if ({a11, a12, a21, a22} !== {3'd1, 3'd2, 3'd3, 3'd4}) begin
      miscompares++;
      $display("FAIL basic_elems: got %0d %0d %0d %0d, want 1 2 3 4", a11, a12, a21, a22);
    end
    vectors++;
    if ({w_out_valid, t11, t12, t21, t22} !== {1'b1, 3'd1, 3'd3, 3'd2, 3'd4}) begin
      miscompares++;
      $display("FAIL wrap_transpose: got ov=%b %0d %0d %0d %0d, want ov=1 1 3 2 4",
               w_out_valid, t11, t12, t21, t22);
    end
    step();
    vectors++;
    if ({out_valid, fill_idx, mat_count} !== {1'b0, 2'd0, 8'd1}) begin
      miscompares++;
      $display("FAIL basic_handoff: got ov=%b idx=%0d cnt=%0d, want ov=0 idx=0 cnt=1",
               out_valid, fill_idx, mat_count);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(3'd5); send(3'd6); send(3'd7); send(3'd0);
    // Offer a stray element during the stall; it must not be taken.
    in_valid = 1'b1;
    in_data  = 3'd3;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if ({out_valid, in_ready, a11, a12, a21, a22, mat_count} !==
          {1'b1, 1'b0, 3'd5, 3'd6, 3'd7, 3'd0, 8'd1}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got ov=%b ir=%b %0d %0d %0d %0d cnt=%0d, want ov=1 ir=0 5 6 7 0 cnt=1",
                 c, out_valid, in_ready, a11, a12, a21, a22, mat_count);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    vectors++;
    if ({out_valid, fill_idx, mat_count} !== {1'b0, 2'd0, 8'd2}) begin
      miscompares++;
      $display("FAIL stall_release: got ov=%b idx=%0d cnt=%0d, want ov=0 idx=0 cnt=2",
               out_valid, fill_idx, mat_count);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    send(3'd1); send(3'd2); send(3'd3); send(3'd4);
    out_ready = 1'b1;
    send(3'd7);
    vectors++;
    if ({out_valid, fill_idx, mat_count} !== {1'b0, 2'd1, 8'd3}) begin
      miscompares++;
      $display("FAIL b2b_ctrl: got ov=%b idx=%0d cnt=%0d, want ov=0 idx=1 cnt=3",
               out_valid, fill_idx, mat_count);
    end
    vectors++;
    if ({a11, a12, a21, a22} !== {3'd7, 3'd2, 3'd3, 3'd4}) begin
      miscompares++;
      $display("FAIL b2b_elems: got %0d %0d %0d %0d, want 7 2 3 4", a11, a12, a21, a22);
    end
  endtask

  task automatic test_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    send(3'd5); send(3'd6);
    vectors++;
    if (fill_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL clear_pre: got idx=%0d want 2", fill_idx);
    end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 3'd6;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    vectors++;
    if ({fill_idx, a11, a12, a21} !== {2'd0, 3'd5, 3'd6, 3'd3}) begin
      miscompares++;
      $display("FAIL clear_wins: got idx=%0d a11=%0d a12=%0d a21=%0d, want idx=0 5 6 3",
               fill_idx, a11, a12, a21);
    end
    out_ready = 1'b0;
    send(3'd1); send(3'd1); send(3'd2); send(3'd2);
    vectors++;
    if ({out_valid, a11, a12, a21, a22} !== {1'b1, 3'd1, 3'd1, 3'd2, 3'd2}) begin
      miscompares++;
      $display("FAIL clear_refill: got ov=%b %0d %0d %0d %0d, want ov=1 1 1 2 2",
               out_valid, a11, a12, a21, a22);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vectors++;
    if ({out_valid, fill_idx, a11, a12, a21, a22} !== {1'b1, 2'd0, 3'd1, 3'd1, 3'd2, 3'd2}) begin
      miscompares++;
      $display("FAIL clear_in_full: got ov=%b idx=%0d %0d %0d %0d %0d, want ov=1 idx=0 1 1 2 2",
               out_valid, fill_idx, a11, a12, a21, a22);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if ({out_valid, mat_count} !== {1'b0, 8'd4}) begin
      miscompares++;
      $display("FAIL clear_handoff: got ov=%b cnt=%0d, want ov=0 cnt=4", out_valid, mat_count);
    end
  endtask

  task automatic test_async_reset();
    send(3'd1); send(3'd2);
    vectors++;
    if (fill_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL arst_pre_fill: got idx=%0d want 2", fill_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, fill_idx, mat_count, a11, a12, a21, a22} !== {1'b0, 2'd0, 8'd0, 12'h000}) begin
      miscompares++;
      $display("FAIL arst_mid_fill: got ov=%b idx=%0d cnt=%0d %0d %0d %0d %0d, want all 0",
               out_valid, fill_idx, mat_count, a11, a12, a21, a22);
    end
    #3 rst_n = 1'b1;
    out_ready = 1'b0;
    step();
    send(3'd3); send(3'd4); send(3'd5); send(3'd6);
    vectors++;
    if ({out_valid, a22} !== {1'b1, 3'd6}) begin
      miscompares++;
      $display("FAIL arst_pre_hold: got ov=%b a22=%0d, want ov=1 a22=6", out_valid, a22);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, fill_idx, mat_count, a11, a12, a21, a22} !== {1'b0, 2'd0, 8'd0, 12'h000}) begin
      miscompares++;
      $display("FAIL arst_mid_hold: got ov=%b idx=%0d cnt=%0d %0d %0d %0d %0d, want all 0",
               out_valid, fill_idx, mat_count, a11, a12, a21, a22);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_count_wrap();
    out_ready = 1'b1;
    for (int m = 0; m < 256; m++) begin
      in_valid = 1'b1;
      for (int e = 0; e < 4; e++) begin
        in_data = W'(e);
        step();
      end
      in_valid = 1'b0;
      step();
      if (m == 254) begin
        vectors++;
        if (mat_count !== 8'd255) begin
          miscompares++;
          $display("FAIL wrap_255: got cnt=%0d want 255", mat_count);
        end
      end
    end
    vectors++;
    if ({out_valid, fill_idx, mat_count} !== {1'b0, 2'd0, 8'd0}) begin
      miscompares++;
      $display("FAIL wrap_zero: got ov=%b idx=%0d cnt=%0d, want ov=0 idx=0 cnt=0",
               out_valid, fill_idx, mat_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_stall();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
